regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two write ports,
// optional bypass / zero register and a one-entry-per-cycle soft clear.
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD-1:0]          rd_en,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic                       clr_req,
    output logic                       busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rv  [NUM_RD];
    logic                wr_ok;
    logic                w0;
    logic                w1;

    // Writes are refused on the request edge and throughout a clear
    assign wr_ok = (state == IDLE) && !clr_req;
    assign w0 = we0 && wr_ok
             && !(ZERO_REG != 0 && waddr0 == '0);
    assign w1 = we1 && wr_ok
             && !(ZERO_REG != 0 && waddr1 == '0)
             && !(w0 && waddr1 == waddr0);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (clr_req) state_n = CLEAR;
            CLEAR:   if (cnt == {ADDR_W{1'b1}}) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == CLEAR);
            if (state == CLEAR) cnt <= cnt + 1'b1;
            else                cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (state == CLEAR) mem[cnt] <= '0;
            if (w0) mem[waddr0] <= wdata0;
            if (w1) mem[waddr1] <= wdata1;
        end
    end

    // Port 0 forwarding is applied last so it wins over port 1
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rv[k] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
            if (BYPASS != 0 && w1
                && waddr1 == rd_addr[k*ADDR_W +: ADDR_W])
                rv[k] = wdata1;
            if (BYPASS != 0 && w0
                && waddr0 == rd_addr[k*ADDR_W +: ADDR_W])
                rv[k] = wdata0;
            if (ZERO_REG != 0
                && rd_addr[k*ADDR_W +: ADDR_W] == '0)
                rv[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++)
                if (rd_en[k]) rd_data[k*DATA_W +: DATA_W] <= rv[k];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp: two instances
// (bypass/no-zero and no-bypass/zero-reg) checked against one model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [1:0]  rd_en = '0;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        we0 = 1'b0;
    logic [3:0]  waddr0 = '0;
    logic [15:0] wdata0 = '0;
    logic        we1 = 1'b0;
    logic [3:0]  waddr1 = '0;
    logic [15:0] wdata1 = '0;
    logic        clr_req = 1'b0;
    logic        busy_a;
    logic        busy_b;

    int checks = 0;
    int errors = 0;

    // model state: [cfg][entry]; cfg 0 = bypass, cfg 1 = zero reg
    logic [15:0] mm [2][16];
    logic [15:0] er [2][2];
    int          clr_left;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data_a),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .clr_req(clr_req), .busy(busy_a)
    );

    regfile_mp #(.BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .clr_req(clr_req), .busy(busy_b)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) mm[c][i] = '0;
            er[c][0] = '0;
            er[c][1] = '0;
        end
        clr_left = 0;
    endtask

    // Applies the register-file rules to the current inputs
    task automatic model_edge();
        bit          acc;
        bit          byp;
        bit          zr;
        logic [3:0]  a;
        logic [15:0] v;
        acc = (clr_left == 0) && !clr_req;
        for (int c = 0; c < 2; c++) begin
            byp = (c == 0);
            zr  = (c == 1);
            for (int k = 0; k < 2; k++) begin
                if (rd_en[k]) begin
                    a = rd_addr[k*4 +: 4];
                    v = mm[c][a];
                    if (byp && acc && we1 && waddr1 == a) v = wdata1;
                    if (byp && acc && we0 && waddr0 == a) v = wdata0;
                    if (zr && a == 0) v = '0;
                    er[c][k] = v;
                end
            end
            if (acc) begin
                if (we1 && !(zr && waddr1 == 0)) mm[c][waddr1] = wdata1;
                if (we0 && !(zr && waddr0 == 0)) mm[c][waddr0] = wdata0;
            end
        end
        if (clr_left > 0) begin
            mm[0][16-clr_left] = '0;
            mm[1][16-clr_left] = '0;
            clr_left--;
        end else if (clr_req) begin
            clr_left = 16;
        end
    endtask

    task automatic compare_all(input string where);
        check($sformatf("%s a.rd0", where), {16'h0, rd_data_a[15:0]}, {16'h0, er[0][0]});
        check($sformatf("%s a.rd1", where), {16'h0, rd_data_a[31:16]}, {16'h0, er[0][1]});
        check($sformatf("%s b.rd0", where), {16'h0, rd_data_b[15:0]}, {16'h0, er[1][0]});
        check($sformatf("%s b.rd1", where), {16'h0, rd_data_b[31:16]}, {16'h0, er[1][1]});
        check($sformatf("%s a.busy", where), {31'h0, busy_a}, {31'h0, clr_left > 0});
        check($sformatf("%s b.busy", where), {31'h0, busy_b}, {31'h0, clr_left > 0});
    endtask

    task automatic step(input string where);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(where);
    endtask

    task automatic idle_in();
        we0 = 0; we1 = 0; clr_req = 0; rd_en = 2'b00;
    endtask

    task automatic do_reset(input string where);
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all(where);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic read_all(input string where);
        for (int i = 0; i < 16; i++) begin
            idle_in();
            rd_en = 2'b11;
            rd_addr = {i[3:0], i[3:0]};
            step(where);
        end
    endtask

    initial begin
        int bc;
        model_reset();
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step("warm");

        // mid-sim reset then read everything
        do_reset("rst");
        read_all("rst_read");

        // basic write, 1-cycle latency, hold on rd_en=0
        idle_in();
        we0 = 1; waddr0 = 3; wdata0 = 16'hA5A5;
        step("wr3");
        idle_in();
        rd_en = 2'b01; rd_addr = 8'h03;
        step("rd3");
        check("rd3_const", {16'h0, rd_data_a[15:0]}, 32'hA5A5);
        idle_in();
        rd_addr = 8'h00;
        step("hold");
        check("hold_const", {16'h0, rd_data_a[15:0]}, 32'hA5A5);

        // collision + same-cycle read on port 1
        idle_in();
        we0 = 1; we1 = 1; waddr0 = 7; waddr1 = 7;
        wdata0 = 16'h1111; wdata1 = 16'h2222;
        rd_en = 2'b10; rd_addr = 8'h70;
        step("coll");
        check("coll_byp", {16'h0, rd_data_a[31:16]}, 32'h1111);
        check("coll_nobyp", {16'h0, rd_data_b[31:16]}, 32'h0000);
        idle_in();
        rd_en = 2'b11; rd_addr = 8'h77;
        step("coll_rd");
        check("coll_a7", {16'h0, rd_data_a[15:0]}, 32'h1111);
        check("coll_b7", {16'h0, rd_data_b[31:16]}, 32'h1111);

        // zero register with bypass read of address 0
        idle_in();
        we0 = 1; we1 = 1; waddr0 = 0; waddr1 = 0;
        wdata0 = 16'hFFFF; wdata1 = 16'hFFFF;
        rd_en = 2'b01; rd_addr = 8'h00;
        step("zr_wr");
        check("zr_byp_b", {16'h0, rd_data_b[15:0]}, 32'h0000);
        idle_in();
        rd_en = 2'b11; rd_addr = 8'h00;
        step("zr_rd");
        check("zr_rd_b", {16'h0, rd_data_b[15:0]}, 32'h0000);
        check("zr_rd_a", {16'h0, rd_data_a[15:0]}, 32'hFFFF);

        // soft clear
        for (int i = 0; i < 16; i++) begin
            idle_in();
            we0 = 1; waddr0 = i[3:0]; wdata0 = 16'h0100 + 16'(i);
            step("fill");
        end
        idle_in();
        clr_req = 1;
        step("clr_start");
        bc = 0;
        while (busy_a && bc < 40) begin
            bc++;
            idle_in();
            if (bc == 5) begin
                we0 = 1; waddr0 = 2; wdata0 = 16'hBEEF;
            end
            if (bc == 8) clr_req = 1;
            if (bc == 10) begin
                rd_en = 2'b01; rd_addr = 8'h0F;
            end
            step("clr");
            if (bc == 10)
                check("clr_rd15", {16'h0, rd_data_a[15:0]}, 32'h010F);
        end
        check("busy_len", bc, 16);
        read_all("clr_read");
        idle_in();
        rd_en = 2'b11; rd_addr = 8'h22;
        step("clr_e2");
        check("clr_e2_a", {16'h0, rd_data_a[15:0]}, 32'h0000);

        // reset during a clear
        for (int i = 0; i < 16; i++) begin
            idle_in();
            we0 = 1; waddr0 = i[3:0]; wdata0 = 16'($urandom);
            step("fill2");
        end
        idle_in();
        clr_req = 1;
        step("clr2");
        idle_in();
        repeat (4) step("clr2_run");
        check("clr2_busy", {31'h0, busy_a}, 32'h1);
        do_reset("rst_mid");
        read_all("rst_mid_read");
        idle_in();
        we0 = 1; waddr0 = 5; wdata0 = 16'h1234;
        step("post_wr");
        idle_in();
        rd_en = 2'b01; rd_addr = 8'h05;
        step("post_rd");
        check("post_rd_const", {16'h0, rd_data_a[15:0]}, 32'h1234);

        // randomised traffic
        for (int n = 0; n < 600; n++) begin
            we0 = 1'($urandom);
            we1 = 1'($urandom);
            waddr0 = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            waddr1 = 4'($urandom_range(0, 2) == 0 ? waddr0 : 4'($urandom));
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            rd_en = 2'($urandom);
            rd_addr = {4'($urandom_range(0, 2) == 0 ? waddr1 : 4'($urandom)),
                       4'($urandom_range(0, 2) == 0 ? waddr0 : 4'($urandom))};
            clr_req = ($urandom_range(0, 49) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
